// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
//
// Parametrised UART transmitter with configurable payload width, parity mode
// and stop-bit count. It also drives an RS-485 transceiver enable (dir) that
// stays high for a programmable number of bit times after the last stop bit.
// A word offered during that hold window starts the next frame immediately,
// with no idle gap and no low glitch on dir.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous active-high reset (abandons any frame)
//   valid    in   producer has a word on pi_data
//   pi_data  in   word to send, LSB first (DATA_BITS wide)
//   ready    out  block accepts a word this cycle (IDLE or HOLD)
//   tx       out  serial line, idle high
//   dir      out  transceiver driver enable, high while driving
//   tx_done  out  one-cycle pulse coincident with the last stop-bit cycle
//
// Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,   // 0 none, 1 even, 2 odd
  parameter int STOP_BITS = 1,
  parameter int DIR_HOLD  = 1    // bit times dir stays high after the frame
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic [DATA_BITS-1:0] pi_data,
  output logic                 ready,
  output logic                 tx,
  output logic                 dir,
  output logic                 tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [3:0]       HOLD_LAST = 4'((DIR_HOLD > 0) ? DIR_HOLD - 1 : 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;

  // Reject illegal configurations while elaborating.
  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_frame: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (DIR_HOLD < 0 || DIR_HOLD > 3) begin : g_bad_dir_hold
      $error("uart_tx_frame: DIR_HOLD must be in 0..3");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_frame: CLK_FREQ/BAUD must be at least 2");
    end
  endgenerate

  logic [2:0]           state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [3:0]           idx_reg, idx_next;     // data bit / stop bit / hold bit index
  logic [DATA_BITS-1:0] sr_reg, sr_next;       // payload shift register
  logic                 par_reg, par_next;
  logic                 tx_reg, tx_next;
  logic                 dir_reg, dir_next;
  logic                 ready_reg, ready_next;
  logic                 done_reg, done_next;

  logic accept;
  logic bit_end;
  logic word_parity;

  assign accept  = valid && ready_reg;
  assign bit_end = (cnt_reg == '0);
  // Even parity bit makes the total count of ones even; odd inverts it.
  assign word_parity = (PARITY == 2) ? ~(^pi_data) : (^pi_data);

  always_comb begin
    state_next = state_reg;
    cnt_next   = bit_end ? CNT_LAST : cnt_reg - 1'b1;
    idx_next   = idx_reg;
    sr_next    = sr_reg;
    par_next   = par_reg;
    tx_next    = tx_reg;
    dir_next   = dir_reg;
    ready_next = ready_reg;
    done_next  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        cnt_next   = CNT_LAST;
        tx_next    = 1'b1;
        dir_next   = 1'b0;
        ready_next = 1'b1;
        if (accept) begin
          state_next = S_START;
          sr_next    = pi_data;
          par_next   = word_parity;
          tx_next    = 1'b0;
          dir_next   = 1'b1;
          ready_next = 1'b0;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_next = S_DATA;
          idx_next   = '0;
          tx_next    = sr_reg[0];
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (idx_reg == DATA_LAST) begin
            idx_next = '0;
            if (PARITY != 0) begin
              state_next = S_PAR;
              tx_next    = par_reg;
            end else begin
              state_next = S_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            // tx takes the next bit while the register shifts toward it.
            idx_next = idx_reg + 4'd1;
            sr_next  = {1'b0, sr_reg[DATA_BITS-1:1]};
            tx_next  = sr_reg[1];
          end
        end
      end

      S_PAR: begin
        if (bit_end) begin
          state_next = S_STOP;
          idx_next   = '0;
          tx_next    = 1'b1;
        end
      end

      S_STOP: begin
        // Registered pulse: raise it one cycle early so it lands on the
        // final stop-bit cycle.
        done_next = (idx_reg == STOP_LAST) && (cnt_reg == CNT_ONE);
        if (bit_end) begin
          if (idx_reg == STOP_LAST) begin
            idx_next   = '0;
            ready_next = 1'b1;
            if (DIR_HOLD == 0) begin
              state_next = S_IDLE;
              dir_next   = 1'b0;
            end else begin
              state_next = S_HOLD;
            end
          end else begin
            idx_next = idx_reg + 4'd1;
          end
        end
      end

      S_HOLD: begin
        if (accept) begin
          // Next frame starts at once; dir is already high and stays high.
          state_next = S_START;
          cnt_next   = CNT_LAST;
          sr_next    = pi_data;
          par_next   = word_parity;
          tx_next    = 1'b0;
          ready_next = 1'b0;
        end else if (bit_end) begin
          if (idx_reg == HOLD_LAST) begin
            state_next = S_IDLE;
            dir_next   = 1'b0;
          end else begin
            idx_next = idx_reg + 4'd1;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
        tx_next    = 1'b1;
        dir_next   = 1'b0;
        ready_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      sr_reg    <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
      dir_reg   <= 1'b0;
      ready_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      sr_reg    <= sr_next;
      par_reg   <= par_next;
      tx_reg    <= tx_next;
      dir_reg   <= dir_next;
      ready_reg <= ready_next;
      done_reg  <= done_next;
    end
  end

  assign ready   = ready_reg;
  assign tx      = tx_reg;
  assign dir     = dir_reg;
  assign tx_done = done_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame
//
// Five transmitter instances with different configurations share one clock:
//   0: defaults (50 MHz, 9600 baud, 8N1, hold 1)
//   1: 16 clocks/bit, 7 data bits, even parity, 2 stop bits, hold 1
//   2: same as 1 with odd parity
//   3: 16 clocks/bit, 8N1, hold 2 (back-to-back and reset tests)
//   4: 16 clocks/bit, 9 data bits, no parity, 1 stop bit, hold 0
// A reference model builds the expected per-cycle {tx,dir,tx_done,ready}
// waveform from the frame's bit list; the selected instance is recorded one
// cycle at a time and compared against it.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame;

  localparam int CPB_S = 16;
  localparam int CPB_D = 50000000 / 9600;
  localparam int MAXN  = 60000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] rst_v, valid_v, ready_v, tx_v, dir_v, done_v;
  logic [7:0] d0, d3;
  logic [6:0] d1, d2;
  logic [8:0] d4;
  logic [2:0] sel;

  int errors = 0;
  int checks = 0;

  logic [3:0] obs_v [MAXN];
  logic [3:0] exp_v [MAXN];

  uart_tx_frame u_def (
    .clk(clk), .rst(rst_v[0]), .valid(valid_v[0]), .pi_data(d0),
    .ready(ready_v[0]), .tx(tx_v[0]), .dir(dir_v[0]), .tx_done(done_v[0]));

  uart_tx_frame #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(7), .PARITY(1),
                  .STOP_BITS(2), .DIR_HOLD(1)) u_even (
    .clk(clk), .rst(rst_v[1]), .valid(valid_v[1]), .pi_data(d1),
    .ready(ready_v[1]), .tx(tx_v[1]), .dir(dir_v[1]), .tx_done(done_v[1]));

  uart_tx_frame #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(2), .DIR_HOLD(1)) u_odd (
    .clk(clk), .rst(rst_v[2]), .valid(valid_v[2]), .pi_data(d2),
    .ready(ready_v[2]), .tx(tx_v[2]), .dir(dir_v[2]), .tx_done(done_v[2]));

  uart_tx_frame #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .DIR_HOLD(2)) u_b2b (
    .clk(clk), .rst(rst_v[3]), .valid(valid_v[3]), .pi_data(d3),
    .ready(ready_v[3]), .tx(tx_v[3]), .dir(dir_v[3]), .tx_done(done_v[3]));

  uart_tx_frame #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(9), .PARITY(0),
                  .STOP_BITS(1), .DIR_HOLD(0)) u_nine (
    .clk(clk), .rst(rst_v[4]), .valid(valid_v[4]), .pi_data(d4),
    .ready(ready_v[4]), .tx(tx_v[4]), .dir(dir_v[4]), .tx_done(done_v[4]));

  // Reference model. Index 0 is the first START cycle. The frame is the
  // bit list start, data LSB first, optional parity, stop bits, each held
  // cpb cycles; dir stays high through the hold window; ready is high once
  // the frame is over; tx_done marks the final frame cycle. Two idle cycles
  // follow. Returns the number of cycles described.
  function automatic int build_expect(input int dbits, input int par,
                                      input int stops, input int hold,
                                      input int cpb, input logic [8:0] word);
    int   bits[$];
    int   ones;
    int   flen;
    int   n;
    logic t, d, dn, r;
    ones = 0;
    bits.push_back(0);
    for (int i = 0; i < dbits; i++) begin
      bits.push_back(int'(word[i]));
      ones += int'(word[i]);
    end
    if (par == 1) bits.push_back(ones % 2);
    else if (par == 2) bits.push_back(1 - (ones % 2));
    for (int i = 0; i < stops; i++) bits.push_back(1);
    flen = bits.size() * cpb;
    n    = flen + hold * cpb + 2;
    for (int k = 0; k < n; k++) begin
      t  = (k < flen) ? (bits[k / cpb] != 0) : 1'b1;
      d  = (k < flen + hold * cpb);
      dn = (k == flen - 1);
      r  = (k >= flen);
      exp_v[k] = {t, d, dn, r};
    end
    return n;
  endfunction

  // Records n cycles of the selected instance, one per falling edge.
  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      obs_v[k] = {tx_v[sel], dir_v[sel], done_v[sel], ready_v[sel]};
      @(negedge clk);
    end
  endtask

  // Presents one word for one cycle; returns on the first START cycle.
  task automatic send(input logic [8:0] w);
    case (sel)
      3'd0: d0 = w[7:0];
      3'd1: d1 = w[6:0];
      3'd2: d2 = w[6:0];
      3'd3: d3 = w[7:0];
      default: d4 = w;
    endcase
    valid_v[sel] = 1'b1;
    @(negedge clk);
    valid_v[sel] = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] o;
    rst_v   = '1;
    valid_v = '0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0; d4 = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      sel = 3'(i);
      o = {tx_v[sel], dir_v[sel], done_v[sel], ready_v[sel]};
      checks++;
      if (o !== 4'b1000) begin
        errors++;
        $display("FAIL reset_hold inst %0d {tx,dir,done,ready} got %b want 1000", i, o);
      end
    end
    rst_v = '0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      sel = 3'(i);
      o = {tx_v[sel], dir_v[sel], done_v[sel], ready_v[sel]};
      checks++;
      if (o !== 4'b1001) begin
        errors++;
        $display("FAIL reset_release inst %0d {tx,dir,done,ready} got %b want 1001", i, o);
      end
    end
  endtask

  task automatic test_default_8n1();
    int n;
    sel = 3'd0;
    n = build_expect(8, 0, 1, 1, CPB_D, 9'h055);
    send(9'h055);
    capture(n);
    for (int k = 0; k < n; k++) begin
      checks++;
      if (obs_v[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL default_8n1 cycle %0d {tx,dir,done,ready} got %b want %b", k + 1, obs_v[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_parity(input logic [2:0] inst, input int par);
    int n;
    logic [8:0] w;
    sel = inst;
    for (int f = 0; f < 5; f++) begin
      w = (f == 0) ? 9'h043 : 9'($urandom_range(0, 127));
      n = build_expect(7, par, 2, 1, CPB_S, w);
      send(w);
      // Later changes on pi_data must not reach the line.
      if (inst == 3'd1) d1 = ~w[6:0];
      else d2 = ~w[6:0];
      capture(n);
      for (int k = 0; k < n; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL parity%0d word %h cycle %0d {tx,dir,done,ready} got %b want %b", par, w, k + 1, obs_v[k], exp_v[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int flen;
    logic [3:0] o;
    sel  = 3'd3;
    flen = 10 * CPB_S;
    // First word, valid held high across the whole first frame.
    void'(build_expect(8, 0, 1, 2, CPB_S, 9'h0A0));
    d3 = 8'hA0;
    valid_v[3] = 1'b1;
    @(negedge clk);
    d3 = 8'h0F;
    capture(flen);
    for (int k = 0; k < flen; k++) begin
      checks++;
      if (obs_v[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL b2b_first cycle %0d {tx,dir,done,ready} got %b want %b", k + 1, obs_v[k], exp_v[k]);
      end
    end
    // First hold cycle: ready high, dir still high; the edge ahead accepts.
    o = {tx_v[3], dir_v[3], done_v[3], ready_v[3]};
    checks++;
    if (o !== 4'b1101) begin
      errors++;
      $display("FAIL b2b_hold_cycle {tx,dir,done,ready} got %b want 1101", o);
    end
    @(negedge clk);
    valid_v[3] = 1'b0;
    n = build_expect(8, 0, 1, 2, CPB_S, 9'h00F);
    capture(n);
    for (int k = 0; k < n; k++) begin
      checks++;
      if (obs_v[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL b2b_second cycle %0d {tx,dir,done,ready} got %b want %b", k + 1, obs_v[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    logic [8:0] w;
    logic [3:0] o;
    sel = 3'd3;
    w = 9'($urandom_range(0, 255));
    send(w);
    // Cycle 69 lies inside data bit 3 (cycles 65..80).
    repeat (68) @(negedge clk);
    checks++;
    if (tx_v[3] !== w[3]) begin
      errors++;
      $display("FAIL mid_frame_bit3 tx got %b want %b", tx_v[3], w[3]);
    end
    rst_v[3] = 1'b1;
    @(negedge clk);
    o = {tx_v[3], dir_v[3], done_v[3], ready_v[3]};
    checks++;
    if (o !== 4'b1000) begin
      errors++;
      $display("FAIL mid_frame_reset {tx,dir,done,ready} got %b want 1000", o);
    end
    rst_v[3] = 1'b0;
    @(negedge clk);
    o = {tx_v[3], dir_v[3], done_v[3], ready_v[3]};
    checks++;
    if (o !== 4'b1001) begin
      errors++;
      $display("FAIL mid_frame_release {tx,dir,done,ready} got %b want 1001", o);
    end
    w = {1'b0, ~w[7:0]};
    n = build_expect(8, 0, 1, 2, CPB_S, w);
    send(w);
    capture(n);
    for (int k = 0; k < n; k++) begin
      checks++;
      if (obs_v[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL after_reset word %h cycle %0d {tx,dir,done,ready} got %b want %b", w, k + 1, obs_v[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_dir_hold0();
    int n;
    logic [8:0] w;
    sel = 3'd4;
    for (int f = 0; f < 4; f++) begin
      w = (f == 0) ? 9'h1FF : 9'($urandom_range(0, 511));
      n = build_expect(9, 0, 1, 0, CPB_S, w);
      send(w);
      d4 = 9'h000;
      capture(n);
      for (int k = 0; k < n; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL hold0 word %h cycle %0d {tx,dir,done,ready} got %b want %b", w, k + 1, obs_v[k], exp_v[k]);
        end
      end
    end
  endtask

  initial begin
    sel = 3'd0;
    test_reset();
    test_default_8n1();
    test_parity(3'd1, 1);
    test_parity(3'd2, 2);
    test_back_to_back();
    test_reset_mid_frame();
    test_dir_hold0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
